// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, widths, reset PC, step sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro used by importers: FETCH_RVC_EN.
package if_fetch_ctrl_pkg;

    localparam int              FETCH_XLEN     = 32;
    localparam logic [31:0]     FETCH_RESET_PC = 32'h8000_0000;
    localparam logic [31:0]     FETCH_STEP_4   = 32'd4;
    localparam logic [31:0]     FETCH_STEP_2   = 32'd2;

    // REQ: may issue a request; WAIT: awaiting a live response;
    // DROP: awaiting a response that a redirect made stale.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_next_pc.sv
// Sequential-PC adder: pc + 4, or pc + 2 for a compressed instruction when FETCH_RVC_EN is defined.
// Latency: combinational.
// Backpressure: none.
// Ports: pc_i (current PC), rdata_lo_i (fetched instruction bits [1:0]), next_pc_o (pc + step, wraps).
module if_next_pc
    import if_fetch_ctrl_pkg::*;
#(
    parameter int XLEN = FETCH_XLEN
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      rdata_lo_i,
    output logic [XLEN-1:0] next_pc_o
);

    logic [XLEN-1:0] step;

`ifdef FETCH_RVC_EN
    // Low bits other than 2'b11 mark a 16-bit compressed instruction.
    assign step = (rdata_lo_i != 2'b11) ? XLEN'(FETCH_STEP_2) : XLEN'(FETCH_STEP_4);
`else
    logic unused_rdata_lo;
    assign unused_rdata_lo = ^rdata_lo_i;
    assign step            = XLEN'(FETCH_STEP_4);
`endif

    // Plain XLEN-bit add: the carry out is dropped so the PC wraps.
    assign next_pc_o = pc_i + step;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one icache request at a time, buffers one response for pre-IF.
// Latency: request accepted in N, response in N+k, fetch_valid_o at N+k+1.
// Backpressure: stall_i holds a full buffer and blocks new requests; redirect flushes buffer and stale responses.
// Ports: clk/rst (sync, active-high); redirect_valid_i/redirect_pc_i; stall_i;
//        icache_req_valid_o/icache_req_ready_i/icache_req_addr_o; icache_rdata_valid_i/icache_rdata_i;
//        fetch_addr_o/fetch_inst_o/fetch_valid_o/fetch_stall_o to pre-IF.
// Optional feature macro: FETCH_RVC_EN (2-byte step and 2-byte redirect alignment).
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            icache_req_valid_o,
    input  logic            icache_req_ready_i,
    output logic [XLEN-1:0] icache_req_addr_o,
    input  logic            icache_rdata_valid_i,
    input  logic [31:0]     icache_rdata_i,
    output logic [XLEN-1:0] fetch_addr_o,
    output logic [31:0]     fetch_inst_o,
    output logic            fetch_valid_o,
    output logic            fetch_stall_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]     buf_inst_q, buf_inst_d;
    logic            buf_vld_q, buf_vld_d;

    logic            buf_free;
    logic            req_fire;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] redirect_pc_aligned;

`ifdef FETCH_RVC_EN
    assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:1], 1'b0};
`else
    assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};
`endif

    if_next_pc #(.XLEN(XLEN)) u_next_pc (
        .pc_i       (pc_q),
        .rdata_lo_i (icache_rdata_i[1:0]),
        .next_pc_o  (next_pc)
    );

    // The buffer can take a new response if it is empty or drains this cycle.
    assign buf_free           = !buf_vld_q || !stall_i;
    assign icache_req_valid_o = (state_q == ST_REQ) && buf_free && !redirect_valid_i && !rst;
    assign icache_req_addr_o  = pc_q;
    assign req_fire           = icache_req_valid_o && icache_req_ready_i;

    assign fetch_addr_o  = buf_addr_q;
    assign fetch_inst_o  = buf_inst_q;
    assign fetch_valid_o = buf_vld_q;
    assign fetch_stall_o = !buf_vld_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_addr_d = buf_addr_q;
        buf_inst_d = buf_inst_q;
        buf_vld_d  = buf_vld_q;

        if (buf_vld_q && !stall_i) begin
            buf_vld_d = 1'b0;
        end

        if (redirect_valid_i) begin
            pc_d       = redirect_pc_aligned;
            buf_vld_d  = 1'b0;
            buf_addr_d = '0;
            buf_inst_d = '0;
            // An outstanding response that has not arrived yet must be swallowed later.
            if (state_q != ST_REQ) begin
                state_d = icache_rdata_valid_i ? ST_REQ : ST_DROP;
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (icache_rdata_valid_i) begin
                        buf_vld_d  = 1'b1;
                        buf_addr_d = pc_q;
                        buf_inst_d = icache_rdata_i;
                        pc_d       = next_pc;
                        state_d    = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (icache_rdata_valid_i) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_inst_q <= buf_inst_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed cycle table, then randomized traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: bench drives stall_i and icache_req_ready_i randomly.
module tb_if_fetch_ctrl;

    localparam logic [31:0] R = 32'h8000_0000;
`ifdef FETCH_RVC_EN
    localparam logic [31:0] ALN102 = 32'h8000_0102;
`else
    localparam logic [31:0] ALN102 = 32'h8000_0100;
`endif

    logic        clk = 1'b0;
    logic        rst, redirect_valid_i, stall_i, icache_req_ready_i, icache_rdata_valid_i;
    logic [31:0] redirect_pc_i, icache_rdata_i;
    logic        icache_req_valid_o, fetch_valid_o, fetch_stall_o;
    logic [31:0] icache_req_addr_o, fetch_addr_o, fetch_inst_o;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .redirect_valid_i     (redirect_valid_i),
        .redirect_pc_i        (redirect_pc_i),
        .stall_i              (stall_i),
        .icache_req_valid_o   (icache_req_valid_o),
        .icache_req_ready_i   (icache_req_ready_i),
        .icache_req_addr_o    (icache_req_addr_o),
        .icache_rdata_valid_i (icache_rdata_valid_i),
        .icache_rdata_i       (icache_rdata_i),
        .fetch_addr_o         (fetch_addr_o),
        .fetch_inst_o         (fetch_inst_o),
        .fetch_valid_o        (fetch_valid_o),
        .fetch_stall_o        (fetch_stall_o)
    );

    int n_chk = 0;
    int n_err = 0;
    int hs_cnt = 0;

    always @(posedge clk) if (icache_req_valid_o && icache_req_ready_i) hs_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        stall, rdy, rv;
        logic [31:0] rdata;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_fv;
        logic [31:0] e_fa, e_fi;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rs, input logic rd, input logic [31:0] rpc, input logic st,
                       input logic rdy, input logic rv, input logic [31:0] rdata, input logic e_rv,
                       input logic [31:0] e_ra, input logic e_fv, input logic [31:0] e_fa,
                       input logic [31:0] e_fi);
        vec_t v;
        v = '{rs, rd, rpc, st, rdy, rv, rdata, e_rv, e_ra, e_fv, e_fa, e_fi};
        vq.push_back(v);
    endtask

    // Behavioural reference: PC, one in-flight flag, a stale marker, and a one-deep buffer.
    logic [31:0] m_pc, m_ba, m_bi;
    logic        m_out, m_stale, m_bvld;
    logic        ic_busy;
    int          ic_wait;
    logic [31:0] ic_data;

    function automatic logic [31:0] align(input logic [31:0] a);
`ifdef FETCH_RVC_EN
        return a & 32'hFFFF_FFFE;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    function automatic logic [31:0] step(input logic [31:0] inst);
`ifdef FETCH_RVC_EN
        return (inst[1:0] == 2'b11) ? 32'd4 : 32'd2;
`else
        return 32'd4;
`endif
    endfunction

    initial begin
        rst = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
        icache_req_ready_i = 1'b0; icache_rdata_valid_i = 1'b0; icache_rdata_i = '0;
        @(negedge clk);

        // ---------------- directed cycle table ----------------
        add(1,0,0,           0,0,0,0,            0,R,         0,0,0);
        add(0,0,0,           0,1,0,0,            1,R,         0,0,0);
        add(0,0,0,           0,1,1,32'h13,       0,R,         0,0,0);
        add(0,0,0,           0,1,0,0,            1,R+4,       1,R,32'h13);
        add(0,0,0,           0,1,1,32'h0010_0093,0,R+4,       0,0,0);
        for (int i = 0; i < 5; i++)
            add(0,0,0,       1,1,0,0,            0,R+8,       1,R+4,32'h0010_0093);
        add(0,0,0,           0,1,0,0,            1,R+8,       1,R+4,32'h0010_0093);
        add(0,1,R+32'h100,   0,1,0,0,            0,R+8,       0,0,0);
        add(0,0,0,           0,1,0,0,            0,R+32'h100, 0,0,0);
        add(0,0,0,           0,1,1,32'hDEAD_BEEF,0,R+32'h100, 0,0,0);
        add(0,0,0,           0,1,0,0,            1,R+32'h100, 0,0,0);
        add(0,1,R+32'h300,   0,1,1,32'h13,       0,R+32'h100, 0,0,0);
        add(0,0,0,           0,1,0,0,            1,R+32'h300, 0,0,0);
        add(0,0,0,           0,1,1,32'h13,       0,R+32'h300, 0,0,0);
        add(0,1,R+32'h102,   1,1,0,0,            0,R+32'h304, 1,R+32'h300,32'h13);
        add(0,0,0,           0,1,0,0,            1,ALN102,    0,0,0);
        add(0,0,0,           0,1,1,32'h4501,     0,ALN102,    0,0,0);
        add(0,0,0,           1,0,0,0,            0,R+32'h104, 1,ALN102,32'h4501);
        add(0,0,0,           0,0,0,0,            1,R+32'h104, 1,ALN102,32'h4501);
        for (int i = 0; i < 3; i++)
            add(0,0,0,       0,0,0,0,            1,R+32'h104, 0,0,0);
        add(0,0,0,           0,1,0,0,            1,R+32'h104, 0,0,0);
        add(1,0,0,           0,0,0,0,            0,R+32'h104, 0,0,0);
        add(0,0,0,           0,0,1,32'h0BAD,     1,R,         0,0,0);
        add(0,0,0,           0,0,0,0,            1,R,         0,0,0);
        add(0,1,32'hFFFF_FFFC,0,1,0,0,           0,R,         0,0,0);
        add(0,0,0,           0,1,0,0,            1,32'hFFFF_FFFC,0,0,0);
        add(0,0,0,           0,1,1,32'h13,       0,32'hFFFF_FFFC,0,0,0);
        add(0,0,0,           0,0,0,0,            1,32'h0,     1,32'hFFFF_FFFC,32'h13);

        hs_cnt = 0;
        for (int i = 0; i < vq.size(); i++) begin
            rst                  = vq[i].rst;
            redirect_valid_i     = vq[i].redir;
            redirect_pc_i        = vq[i].rpc;
            stall_i              = vq[i].stall;
            icache_req_ready_i   = vq[i].rdy;
            icache_rdata_valid_i = vq[i].rv;
            icache_rdata_i       = vq[i].rdata;
            #1;
            chk($sformatf("row%0d req_valid", i), 32'(icache_req_valid_o), 32'(vq[i].e_rv));
            chk($sformatf("row%0d req_addr", i), icache_req_addr_o, vq[i].e_ra);
            chk($sformatf("row%0d fetch_valid", i), 32'(fetch_valid_o), 32'(vq[i].e_fv));
            chk($sformatf("row%0d fetch_stall", i), 32'(fetch_stall_o), 32'(!vq[i].e_fv));
            if (vq[i].e_fv || i == 0) begin
                chk($sformatf("row%0d fetch_addr", i), fetch_addr_o, vq[i].e_fa);
                chk($sformatf("row%0d fetch_inst", i), fetch_inst_o, vq[i].e_fi);
            end
            @(negedge clk);
        end
        chk("table handshakes", 32'(hs_cnt), 32'd8);

        // ---------------- randomized run against the model ----------------
        m_pc = R; m_ba = '0; m_bi = '0; m_out = 0; m_stale = 0; m_bvld = 0;
        ic_busy = 0; ic_wait = 0; ic_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic e_rv, acc;
            rst              = (cyc < 2) || ($urandom_range(299) == 0);
            redirect_valid_i = ($urandom_range(15) == 0);
            redirect_pc_i    = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC - 32'($urandom_range(3)) : $urandom;
            stall_i          = ($urandom_range(2) == 0);
            icache_req_ready_i = ($urandom_range(3) != 0);
            icache_rdata_valid_i = 1'b0;
            icache_rdata_i   = $urandom;
            if (rst) begin
                ic_busy = 0;
            end else if (ic_busy) begin
                if (ic_wait <= 1) begin
                    icache_rdata_valid_i = 1'b1;
                    icache_rdata_i       = ic_data;
                    ic_busy              = 0;
                end else begin
                    ic_wait--;
                end
            end
            #1;
            e_rv = !rst && !m_out && (!m_bvld || !stall_i) && !redirect_valid_i;
            if (cyc > 0) begin
                chk($sformatf("rnd%0d req_valid", cyc), 32'(icache_req_valid_o), 32'(e_rv));
                chk($sformatf("rnd%0d req_addr", cyc), icache_req_addr_o, m_pc);
                chk($sformatf("rnd%0d fetch_valid", cyc), 32'(fetch_valid_o), 32'(m_bvld));
                chk($sformatf("rnd%0d fetch_stall", cyc), 32'(fetch_stall_o), 32'(!m_bvld));
                if (m_bvld) begin
                    chk($sformatf("rnd%0d fetch_addr", cyc), fetch_addr_o, m_ba);
                    chk($sformatf("rnd%0d fetch_inst", cyc), fetch_inst_o, m_bi);
                end
            end
            @(posedge clk);
            acc = e_rv && icache_req_ready_i;
            if (rst) begin
                m_pc = R; m_out = 0; m_stale = 0; m_bvld = 0; m_ba = '0; m_bi = '0;
            end else begin
                if (m_bvld && !stall_i) m_bvld = 0;
                if (redirect_valid_i) begin
                    m_pc = align(redirect_pc_i);
                    m_bvld = 0;
                    if (m_out && !icache_rdata_valid_i) begin
                        m_stale = 1;
                    end else begin
                        m_out = 0; m_stale = 0;
                    end
                end else begin
                    if (icache_rdata_valid_i && m_out) begin
                        if (!m_stale) begin
                            m_bvld = 1; m_ba = m_pc; m_bi = icache_rdata_i;
                            m_pc = m_pc + step(icache_rdata_i);
                        end
                        m_out = 0; m_stale = 0;
                    end
                    if (acc) begin
                        m_out   = 1;
                        m_stale = 0;
                        ic_busy = 1;
                        ic_wait = $urandom_range(1, 3);
                        ic_data = $urandom;
                        if ($urandom_range(1) == 0) ic_data[1:0] = 2'b11;
                    end
                end
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
